// File: rtl/ram_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for a single-port RAM
// with one-cycle read latency; sub-word stores are done as read-modify-write.
module ram_arbiter #(
  parameter int n  = 32,
  parameter int AW = 9
) (
  input  logic          clock,
  input  logic          nReset,
  input  logic          ifReq,
  input  logic [AW-1:0] ifAddr,
  output logic          ifAck,
  output logic [n-1:0]  ifData,
  input  logic          dReq,
  input  logic          dWe,
  input  logic [1:0]    dSize,
  input  logic [1:0]    dOff,
  input  logic [AW-1:0] dAddr,
  input  logic [n-1:0]  dWData,
  output logic          dAck,
  output logic          dErr,
  output logic [n-1:0]  dRData,
  output logic          ramR,
  output logic          ramW,
  output logic [AW-1:0] ramAddr,
  output logic [n-1:0]  ramDataW,
  input  logic [n-1:0]  ramDataR
);

  typedef enum logic [3:0] {
    IDLE, I_RD, I_RSP, D_RD, D_RSP, D_WR, M_RD, M_WR, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  wData_q, wData_d;
  logic [1:0]    size_q, size_d;
  logic [1:0]    off_q, off_d;
  logic          lastFetch_q, lastFetch_d;

  logic          grantData, grantFetch, dMisaligned;
  logic [n-1:0]  merged;

  // lastFetch_q = 1 means fetch won the previous grant, so data wins the next tie.
  assign grantData   = dReq && (!ifReq || lastFetch_q);
  assign grantFetch  = ifReq && !grantData;
  assign dMisaligned = dWe && (((dSize == 2'b01) && dOff[0]) ||
                               (dSize[1] && (dOff != 2'b00)));

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wData_q     <= '0;
      size_q      <= '0;
      off_q       <= '0;
      lastFetch_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wData_q     <= wData_d;
      size_q      <= size_d;
      off_q       <= off_d;
      lastFetch_q <= lastFetch_d;
    end
  end

  // Store lanes into the word read back during M_RD.
  always_comb begin
    merged = ramDataR;
    if (size_q == 2'b00) begin
      case (off_q)
        2'd0:    merged[7:0]   = wData_q[7:0];
        2'd1:    merged[15:8]  = wData_q[7:0];
        2'd2:    merged[23:16] = wData_q[7:0];
        default: merged[31:24] = wData_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wData_q[15:0];
    end else begin
      merged[15:0] = wData_q[15:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wData_d     = wData_q;
    size_d      = size_q;
    off_d       = off_q;
    lastFetch_d = lastFetch_q;
    ifAck       = 1'b0;
    ifData      = '0;
    dAck        = 1'b0;
    dErr        = 1'b0;
    dRData      = '0;
    ramR        = 1'b0;
    ramW        = 1'b0;
    ramAddr     = '0;
    ramDataW    = '0;

    case (state_q)
      IDLE: begin
        if (grantFetch) begin
          addr_d      = ifAddr;
          lastFetch_d = 1'b1;
          state_d     = I_RD;
        end else if (grantData) begin
          addr_d      = dAddr;
          wData_d     = dWData;
          size_d      = dSize;
          off_d       = dOff;
          lastFetch_d = 1'b0;
          if (!dWe)             state_d = D_RD;
          else if (dMisaligned) state_d = ERR;
          else if (dSize[1])    state_d = D_WR;
          else                  state_d = M_RD;
        end
      end
      I_RD: begin
        ramR    = 1'b1;
        ramAddr = addr_q;
        state_d = I_RSP;
      end
      I_RSP: begin
        ifAck   = 1'b1;
        ifData  = ramDataR;
        state_d = IDLE;
      end
      D_RD: begin
        ramR    = 1'b1;
        ramAddr = addr_q;
        state_d = D_RSP;
      end
      D_RSP: begin
        dAck    = 1'b1;
        dRData  = ramDataR;
        state_d = IDLE;
      end
      D_WR: begin
        ramW     = 1'b1;
        ramAddr  = addr_q;
        ramDataW = wData_q;
        dAck     = 1'b1;
        state_d  = IDLE;
      end
      M_RD: begin
        ramR    = 1'b1;
        ramAddr = addr_q;
        state_d = M_WR;
      end
      M_WR: begin
        ramW     = 1'b1;
        ramAddr  = addr_q;
        ramDataW = merged;
        dAck     = 1'b1;
        state_d  = IDLE;
      end
      ERR: begin
        dAck    = 1'b1;
        dErr    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester controller for the core's single-port synchronous data/instruction RAM. Shares the RAM between the instruction-fetch port and the load/store port with round-robin fairness. Sequences every access to match the RAM's one-cycle registered read latency. Performs read-modify-write for byte and halfword stores, because the RAM only writes whole words.

## Interface
- `n`, 32: data width; must be 32.
- `AW`, 9: RAM word-address width.

- `clock`  in  1  system clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `ifReq`  in  1  fetch request; held until `ifAck`.
- `ifAddr`  in  AW  fetch word address.
- `ifAck`  out  1  one-cycle pulse; `ifData` valid this cycle.
- `ifData`  out  n  fetched word.
- `dReq`  in  1  data request; held until `dAck`.
- `dWe`  in  1  1 = store, 0 = load.
- `dSize`  in  2  store size: 00 byte, 01 half, 10 word; 11 is treated as word.
- `dOff`  in  2  byte offset within the word.
- `dAddr`  in  AW  data word address.
- `dWData`  in  n  store data, right-aligned.
- `dAck`  out  1  one-cycle completion pulse.
- `dErr`  out  1  valid with `dAck`; 1 = misaligned, no RAM access made.
- `dRData`  out  n  full loaded word, valid with `dAck`; the load unit extracts and extends it.
- `ramR`, `ramW`  out  1  RAM read and write enables.
- `ramAddr`  out  AW  RAM address.
- `ramDataW`  out  n  RAM write data.
- `ramDataR`  in  n  RAM read data, valid the cycle after `ramR`.

## Operation
- States: IDLE, I_RD, I_RSP, D_RD, D_RSP, D_WR, M_RD, M_WR, ERR.
- IDLE: samples the requests and latches address, data, size and offset of the winner.
- Arbitration:
  - Both requesting: grant the port not granted last.
  - After reset, the last-grant pointer is "fetch", so data wins the first contention.
  - The pointer updates only on a grant.
- Fetch path: IDLE → I_RD (`ramR`=1) → I_RSP (`ifAck`=1, `ifData`=`ramDataR`) → IDLE.
- Load path: IDLE → D_RD (`ramR`) → D_RSP (`dAck`, `dRData`=`ramDataR`) → IDLE.
- Word store: IDLE → D_WR (`ramW`, `ramDataW`=`dWData`, `dAck`) → IDLE.
- Byte/half store: IDLE → M_RD (`ramR`) → M_WR (`ramW`, `dAck`) → IDLE.
  - Merge in M_WR: `ramDataR` with the selected lanes replaced.
  - Byte: bits [8·off+7 : 8·off] ← `dWData[7:0]`.
  - Half: `off[1]` selects the half ← `dWData[15:0]`.
  - Lanes not selected are unchanged.
- Misaligned store goes IDLE → ERR (`dAck`=1, `dErr`=1, no `ramR`/`ramW`) → IDLE.
  - Misaligned half: `off[0]`=1.
  - Misaligned word: `off`≠0.
  - Loads never error; `dOff` is ignored for loads.
- `ramR` and `ramW` are decoded from the state only; never both 1.
- `ifAck` and `dAck` are never high in the same cycle.
- `dErr` is 0 except in ERR.

## Timing
- Latency, counting from the IDLE cycle that sees the request to the ack cycle:
  - Fetch and load: 2 cycles.
  - Word store: 1 cycle.
  - Sub-word store: 2 cycles.
  - Error: 1 cycle.
- One cycle of IDLE separates transactions. Maximum throughput is one access per 2 cycles (word store) or 3 cycles (others).
- Requesters drop `req` on the edge ending the ack cycle, or may present a new request then.
- Requester inputs may change after grant; the latched copies are used.
- Reset values: state IDLE, all outputs 0, latches 0, pointer = fetch.
- Reset asserted mid-transaction abandons it:
  - No ack is produced.
  - A pending RMW write is not performed.
  - `ramW` falls asynchronously with `nReset`.
  - Requesters re-issue after reset.
- A request arriving while another is in flight waits in IDLE arbitration; no request is dropped.

## Test plan
- Reset, then `ifReq` with `ifAddr`=5, RAM word 5 = 0x00A00093 → `ramR` in cycle 1, `ifAck`=1 with `ifData`=0x00A00093 in cycle 2, `dAck` stays 0.
- Store byte: `dSize`=00, `dOff`=2, `dWData`=0xAB into word 0x11223344 → M_RD then M_WR writes 0x11AB3344; `dAck` in cycle 2; exactly one `ramR` and one `ramW`.
- Store half at `dOff`=1 → `dAck`=1 and `dErr`=1 in cycle 1, no RAM enable ever asserted, memory unchanged.
- Both `ifReq` and `dReq` held continuously → grants alternate data, fetch, data, fetch…; no port is granted twice in a row.
- Word store of 0xDEADBEEF to address 3, then load from address 3 → `dRData`=0xDEADBEEF; store ack 1 cycle after sampling, load ack 2 cycles after sampling.
- `nReset` pulsed low during M_RD → no `ramW`, no ack, all outputs 0; after release, the state is IDLE and the re-issued store completes correctly.
